// File: rtl/knn_vote.sv
// Majority-vote reader for a k-nearest-neighbour list: walks knn_id over the
// list, histograms the returned labels and reports the most frequent class.
module knn_vote #(
    parameter int NBR_KNN = 10,
    parameter int CLASS_W = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] knn_id,
    input  logic [7:0] knn_info,
    output logic       busy,
    output logic       done,
    output logic [7:0] label,
    output logic [3:0] votes,
    output logic [2:0] state_dbg
);

    localparam int NBR_CLASS = 1 << CLASS_W;

    typedef enum logic [2:0] {IDLE, CLEAR, READ, SCAN, DONE} state_t;

    state_t state, state_nx;

    logic [3:0]         hist [NBR_CLASS];
    logic [CLASS_W-1:0] scan_idx;
    logic [CLASS_W-1:0] best_label, cand_label;
    logic [3:0]         best_votes, cand_votes;
    logic               last_read, last_scan;
    logic               unused_info;

    assign last_read   = (knn_id == 4'(NBR_KNN - 1));
    assign last_scan   = (scan_idx == CLASS_W'(NBR_CLASS - 1));
    assign unused_info = ^knn_info[7:CLASS_W];

    assign busy      = (state == CLEAR) || (state == READ) || (state == SCAN);
    assign done      = (state == DONE);
    assign state_dbg = state;

    // Strictly-greater replacement keeps the lowest class index on a tie.
    always_comb begin
        cand_label = best_label;
        cand_votes = best_votes;
        if (hist[scan_idx] > best_votes) begin
            cand_label = scan_idx;
            cand_votes = hist[scan_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CLEAR;
            CLEAR:   state_nx = READ;
            READ:    if (last_read) state_nx = SCAN;
            SCAN:    if (last_scan) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            knn_id     <= '0;
            scan_idx   <= '0;
            best_label <= '0;
            best_votes <= '0;
            label      <= '0;
            votes      <= '0;
            for (int i = 0; i < NBR_CLASS; i++) hist[i] <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    knn_id     <= '0;
                    scan_idx   <= '0;
                    best_label <= '0;
                    best_votes <= '0;
                    for (int i = 0; i < NBR_CLASS; i++) hist[i] <= '0;
                end
                READ: begin
                    hist[knn_info[CLASS_W-1:0]] <= hist[knn_info[CLASS_W-1:0]] + 4'd1;
                    knn_id   <= last_read ? 4'd0 : knn_id + 4'd1;
                    scan_idx <= '0;
                end
                SCAN: begin
                    best_label <= cand_label;
                    best_votes <= cand_votes;
                    scan_idx   <= scan_idx + 1'b1;
                    // Results land on the edge into DONE so they are valid with done.
                    if (last_scan) begin
                        label <= 8'(cand_label);
                        votes <= cand_votes;
                    end
                end
                default: knn_id <= '0;
            endcase
        end
    end

endmodule
